// File: rtl/sensor_pwr_seq_if.sv
// Power-sequencer bundle: CPU power request, regulator power-good feedback,
// and the sequenced regulator/clock/reset controls plus status back to the CPU.
interface sensor_pwr_seq_if;
  logic       en_i;
  logic [2:0] pg_i;
  logic       reg_3v3_en_o;
  logic       reg_1v8_en_o;
  logic       reg_1v2_en_o;
  logic       inck_en_o;
  logic       xclr_o;
  logic       ready_o;
  logic       busy_o;
  logic       fault_o;
  logic [3:0] state_o;

  modport master (
    output en_i, pg_i,
    input  reg_3v3_en_o, reg_1v8_en_o, reg_1v2_en_o, inck_en_o, xclr_o,
    input  ready_o, busy_o, fault_o, state_o
  );

  modport slave (
    input  en_i, pg_i,
    output reg_3v3_en_o, reg_1v8_en_o, reg_1v2_en_o, inck_en_o, xclr_o,
    output ready_o, busy_o, fault_o, state_o
  );
endinterface

// File: rtl/sensor_pwr_seq.sv
// SLVS-EC sensor power sequencer: timed rail/INCK/XCLR bring-up with
// power-good supervision, ordered power-down and an emergency FAULT state.
module sensor_pwr_seq #(
  parameter int CNT_W  = 20,
  parameter int T_RAIL = 50000,
  parameter int T_XCLR = 25000,
  parameter int T_DN   = 5000,
  parameter int PG_TO  = 500000
) (
  input  logic           clk,
  input  logic           reset_n,
  sensor_pwr_seq_if.slave pwr
);

  typedef enum logic [3:0] {
    OFF    = 4'd0,
    S_3V3  = 4'd1,
    S_1V8  = 4'd2,
    S_1V2  = 4'd3,
    S_INCK = 4'd4,
    ON     = 4'd5,
    D_XCLR = 4'd6,
    D_INCK = 4'd7,
    D_1V2  = 4'd8,
    D_1V8  = 4'd9,
    D_3V3  = 4'd10,
    FAULT  = 4'd15
  } state_e;

  localparam logic [CNT_W-1:0] RAIL_LAST = CNT_W'(T_RAIL - 1);
  localparam logic [CNT_W-1:0] XCLR_LAST = CNT_W'(T_XCLR - 1);
  localparam logic [CNT_W-1:0] DN_LAST   = CNT_W'(T_DN - 1);
  localparam logic [CNT_W-1:0] PGTO_LAST = CNT_W'(PG_TO - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_meta_q, en_s_q;
  logic [2:0]       pg_meta_q, pg_s_q;
  logic [4:0]       rails_q, rails_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  // Two-flop synchronizers for the asynchronous request and power-good inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
      pg_meta_q <= 3'b000;
      pg_s_q    <= 3'b000;
    end else begin
      en_meta_q <= pwr.en_i;
      en_s_q    <= en_meta_q;
      pg_meta_q <= pwr.pg_i;
      pg_s_q    <= pg_meta_q;
    end
  end

  // Next state: supervision faults win over a withdrawn request, which wins over advancing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (en_s_q) state_d = S_3V3;
        else        state_d = OFF;
      end
      S_3V3: begin
        if (cnt_q == PGTO_LAST && !pg_s_q[2])      state_d = FAULT;
        else if (!en_s_q)                          state_d = D_3V3;
        else if (cnt_q >= RAIL_LAST && pg_s_q[2])  state_d = S_1V8;
        else                                       state_d = S_3V3;
      end
      S_1V8: begin
        if (!pg_s_q[2])                            state_d = FAULT;
        else if (cnt_q == PGTO_LAST && !pg_s_q[1]) state_d = FAULT;
        else if (!en_s_q)                          state_d = D_1V8;
        else if (cnt_q >= RAIL_LAST && pg_s_q[1])  state_d = S_1V2;
        else                                       state_d = S_1V8;
      end
      S_1V2: begin
        if (pg_s_q[2:1] != 2'b11)                  state_d = FAULT;
        else if (cnt_q == PGTO_LAST && !pg_s_q[0]) state_d = FAULT;
        else if (!en_s_q)                          state_d = D_1V2;
        else if (cnt_q >= RAIL_LAST && pg_s_q[0])  state_d = S_INCK;
        else                                       state_d = S_1V2;
      end
      S_INCK: begin
        if (pg_s_q != 3'b111)       state_d = FAULT;
        else if (!en_s_q)           state_d = D_INCK;
        else if (cnt_q == XCLR_LAST) state_d = ON;
        else                        state_d = S_INCK;
      end
      ON: begin
        if (pg_s_q != 3'b111) state_d = FAULT;
        else if (!en_s_q)     state_d = D_XCLR;
        else                  state_d = ON;
      end
      D_XCLR: begin
        if (cnt_q == DN_LAST) state_d = D_INCK;
        else                  state_d = D_XCLR;
      end
      D_INCK: begin
        if (cnt_q == DN_LAST) state_d = D_1V2;
        else                  state_d = D_INCK;
      end
      D_1V2: begin
        if (cnt_q == DN_LAST) state_d = D_1V8;
        else                  state_d = D_1V2;
      end
      D_1V8: begin
        if (cnt_q == DN_LAST) state_d = D_3V3;
        else                  state_d = D_1V8;
      end
      D_3V3: begin
        if (cnt_q == DN_LAST) state_d = OFF;
        else                  state_d = D_3V3;
      end
      FAULT: begin
        if (!en_s_q) state_d = OFF;
        else         state_d = FAULT;
      end
      default: state_d = FAULT;
    endcase
  end

  // Dwell counter restarts on every state change and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else                        cnt_d = cnt_q;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    rails_d = 5'b00000;
    case (state_d)
      S_3V3:   rails_d = 5'b10000;
      S_1V8:   rails_d = 5'b11000;
      S_1V2:   rails_d = 5'b11100;
      S_INCK:  rails_d = 5'b11110;
      ON:      rails_d = 5'b11111;
      D_XCLR:  rails_d = 5'b11110;
      D_INCK:  rails_d = 5'b11100;
      D_1V2:   rails_d = 5'b11000;
      D_1V8:   rails_d = 5'b10000;
      default: rails_d = 5'b00000;
    endcase
    ready_d = (state_d == ON);
    busy_d  = (state_d >= S_3V3) && (state_d <= D_3V3) && (state_d != ON);
    fault_d = (state_d == FAULT);
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
      rails_q <= 5'b00000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rails_q <= rails_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign pwr.reg_3v3_en_o = rails_q[4];
  assign pwr.reg_1v8_en_o = rails_q[3];
  assign pwr.reg_1v2_en_o = rails_q[2];
  assign pwr.inck_en_o    = rails_q[1];
  assign pwr.xclr_o       = rails_q[0];
  assign pwr.ready_o      = ready_q;
  assign pwr.busy_o       = busy_q;
  assign pwr.fault_o      = fault_q;
  assign pwr.state_o      = state_q;

endmodule

// File: tb/tb_sensor_pwr_seq.sv
// Randomized self-checking bench for sensor_pwr_seq; expectations come from
// timeline arithmetic (edges since the request changed) rather than an FSM copy.
module tb_sensor_pwr_seq;
  localparam int T_RAIL = 8;
  localparam int T_XCLR = 4;
  localparam int T_DN   = 3;
  localparam int PG_TO  = 20;
  localparam int T_UP   = 2 + 3 * T_RAIL + T_XCLR;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sensor_pwr_seq_if pif();

  sensor_pwr_seq #(
    .CNT_W(20), .T_RAIL(T_RAIL), .T_XCLR(T_XCLR), .T_DN(T_DN), .PG_TO(PG_TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pwr(pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {pif.reg_3v3_en_o, pif.reg_1v8_en_o, pif.reg_1v2_en_o, pif.inck_en_o,
            pif.xclr_o, pif.ready_o, pif.busy_o, pif.fault_o, pif.state_o};
  endfunction

  // lvl = how many power-up stages are live (3v3,1v8,1v2,inck,xclr); st = state code
  function automatic logic [11:0] exp_vec(int lvl, int st);
    logic [3:0] s4;
    s4 = st[3:0];
    return {lvl >= 1, lvl >= 2, lvl >= 3, lvl >= 4, lvl >= 5,
            st == 5, (st >= 1 && st <= 10 && st != 5), st == 15, s4};
  endfunction

  // Stage reached k edges after en_i is first sampled high (pg all good).
  function automatic int up_stage(int k);
    int s;
    if (k < 2) return 0;
    s = 1 + (k - 2) / T_RAIL;
    if (s <= 3) return s;
    if (k < T_UP) return 4;
    return 5;
  endfunction

  // Down-step state k edges after en_i low is sampled, starting from stage s.
  function automatic int down_state(int s, int k);
    int d;
    if (k < 2) return s;
    d = (11 - s) + (k - 2) / T_DN;
    if (d > 10) return 0;
    return d;
  endfunction

  function automatic int lvl_of(int st);
    if (st == 0 || st == 15) return 0;
    if (st <= 5) return st;
    return 10 - st;
  endfunction

  task automatic go_idle();
    pif.en_i = 1'b0;
    pif.pg_i = 3'b111;
    repeat (2 + 5 * T_DN + 4) step();
  endtask

  task automatic test_reset();
    logic [11:0] e;
    reset_n  = 1'b0;
    pif.en_i = 1'b0;
    pif.pg_i = 3'b111;
    #3;
    e = exp_vec(0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_during got %h exp %h", obs(), e);
    end
    repeat (3) step();
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_after got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_nominal_up();
    logic [11:0] e;
    repeat ($urandom_range(3, 0)) step();
    pif.en_i = 1'b1;
    for (int k = 0; k <= T_UP + 1; k++) begin
      step();
      e = exp_vec(up_stage(k), up_stage(k));
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL nominal_up k=%0d got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_nominal_down();
    logic [11:0] e;
    int st;
    repeat ($urandom_range(4, 0)) step();
    pif.en_i = 1'b0;
    for (int k = 0; k <= 2 + 5 * T_DN + 1; k++) begin
      step();
      st = down_state(5, k);
      e = exp_vec(lvl_of(st), st);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL nominal_down k=%0d got %h exp %h", k, obs(), e);
      end
    end
  endtask

  task automatic test_pg_timeout();
    logic [11:0] e;
    int st;
    pif.pg_i = {1'b1, 1'b0, 1'($urandom_range(1, 0))};
    pif.en_i = 1'b1;
    for (int k = 0; k <= 2 + T_RAIL + PG_TO + 5; k++) begin
      step();
      if (k < 2)                    st = 0;
      else if (k < 2 + T_RAIL)      st = 1;
      else if (k < 2 + T_RAIL + PG_TO) st = 2;
      else                          st = 15;
      e = exp_vec(lvl_of(st), st);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL pg_timeout k=%0d got %h exp %h", k, obs(), e);
      end
    end
    pif.en_i = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      step();
      st = (k < 2) ? 15 : 0;
      e = exp_vec(0, st);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL fault_exit k=%0d got %h exp %h", k, obs(), e);
      end
    end
    go_idle();
  endtask

  task automatic test_pg_loss();
    logic [11:0] e;
    int st;
    int b;
    pif.en_i = 1'b1;
    repeat (T_UP + 1 + $urandom_range(5, 0)) step();
    b = $urandom_range(2, 0);
    pif.pg_i[b] = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      st = (k < 2) ? 5 : 15;
      e = exp_vec(lvl_of(st), st);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL pg_loss bit=%0d k=%0d got %h exp %h", b, k, obs(), e);
      end
    end
    go_idle();
    e = exp_vec(0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL pg_loss_off got %h exp %h", obs(), e);
    end
  endtask

  task automatic test_abort_restart();
    logic [11:0] e;
    int a;
    int kr;
    int st;
    a  = $urandom_range(23, 16);
    kr = $urandom_range(9, 2);
    pif.en_i = 1'b1;
    for (int k = 0; k <= a; k++) begin
      step();
      e = exp_vec(up_stage(k), up_stage(k));
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_up k=%0d got %h exp %h", k, obs(), e);
      end
    end
    pif.en_i = 1'b0;
    // Request comes back mid-down; it only takes effect once OFF is reached.
    for (int k = 0; k <= 2 + 3 * T_DN + T_RAIL + 2; k++) begin
      step();
      if (k <= 2 + 3 * T_DN) st = down_state(3, k);
      else                   st = up_stage(k - (2 + 3 * T_DN + 1) + 2);
      e = exp_vec(lvl_of(st), st);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_down k=%0d got %h exp %h", k, obs(), e);
      end
      if (k == kr) pif.en_i = 1'b1;
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    pif.en_i = 1'b1;
    repeat (T_UP + 1 + $urandom_range(3, 0)) step();
    e = exp_vec(5, 5);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_pre got %h exp %h", obs(), e);
    end
    #1;
    reset_n = 1'b0;
    #1;
    e = exp_vec(0, 0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_no_edge got %h exp %h", obs(), e);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_release got %h exp %h", obs(), e);
    end
    pif.en_i = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    for (int r = 0; r < 3; r++) begin
      test_nominal_up();
      test_nominal_down();
    end
    test_pg_timeout();
    test_pg_loss();
    test_pg_loss();
    test_abort_restart();
    test_abort_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
